// File: rtl/tx_emu_driver.sv
// Emulated serial transmitter: bit FIFO -> +/-1 symbols -> FFE, one output sample per UI.
// Tracks UI time against the emulator timestep and requests the step landing on the next UI edge.
module tx_emu_driver #(
    parameter int DT_WIDTH   = 27,
    parameter int UI_LEN     = 62500,
    parameter int NUM_TAPS   = 3,
    parameter int TAP_WIDTH  = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cke,
    input  logic signed [DT_WIDTH-1:0]      dt,
    output logic signed [DT_WIDTH-1:0]      dt_req,
    input  logic                            din,
    input  logic                            din_valid,
    output logic                            din_ready,
    input  logic [NUM_TAPS*TAP_WIDTH-1:0]   taps,
    output logic signed [OUT_WIDTH-1:0]     out,
    output logic                            out_valid,
    output logic                            underflow,
    output logic                            dt_err
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int HW    = 2 * NUM_TAPS;
    localparam logic signed [DT_WIDTH-1:0] UI_LEN_C = DT_WIDTH'(UI_LEN);
    localparam logic signed [DT_WIDTH-1:0] DT_ZERO  = {DT_WIDTH{1'b0}};
    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b11;

    // Symbols are 2-bit two's complement; the product tap*symbol is just add, subtract or skip.
    function automatic logic signed [OUT_WIDTH-1:0] ffe_sum(
        input logic [NUM_TAPS*TAP_WIDTH-1:0] tp,
        input logic [HW-1:0]                 hs
    );
        logic signed [OUT_WIDTH-1:0] acc;
        logic signed [OUT_WIDTH-1:0] tap_ext;
        logic        [TAP_WIDTH-1:0] t;
        acc = {OUT_WIDTH{1'b0}};
        for (int k = 0; k < NUM_TAPS; k++) begin
            t       = tp[k*TAP_WIDTH +: TAP_WIDTH];
            tap_ext = {{(OUT_WIDTH-TAP_WIDTH){t[TAP_WIDTH-1]}}, t};
            case (hs[2*k +: 2])
                SYM_POS: acc = acc + tap_ext;
                SYM_NEG: acc = acc - tap_ext;
                default: acc = acc;
            endcase
        end
        return acc;
    endfunction

    logic signed [DT_WIDTH-1:0]  t_rem_r;
    logic signed [DT_WIDTH-1:0]  dt_eff_s;
    logic signed [DT_WIDTH-1:0]  t_rem_nxt_s;
    logic                        dt_bad_s;
    logic                        edge_s;
    logic [FIFO_DEPTH-1:0]       mem_r;
    logic [PTR_W-1:0]            wr_ptr_r;
    logic [PTR_W-1:0]            rd_ptr_r;
    logic [CNT_W-1:0]            count_r;
    logic                        empty_s;
    logic                        push_s;
    logic                        pop_s;
    logic [1:0]                  sym_s;
    // Only h[0..NUM_TAPS-2] must be kept: the oldest symbol drops out at every edge.
    logic [HW-3:0]               hist_r;
    logic [HW-1:0]               hist_nxt_s;
    logic signed [OUT_WIDTH-1:0] out_r;
    logic                        out_valid_r;
    logic                        underflow_r;
    logic                        dt_err_r;

    // Clip the applied timestep to [0, t_rem] and detect a UI edge.
    always_comb begin
        dt_eff_s = dt;
        dt_bad_s = 1'b0;
        if (dt < DT_ZERO) begin
            dt_eff_s = DT_ZERO;
            dt_bad_s = 1'b1;
        end else if (dt > t_rem_r) begin
            dt_eff_s = t_rem_r;
            dt_bad_s = 1'b1;
        end else begin
            dt_eff_s = dt;
            dt_bad_s = 1'b0;
        end
        t_rem_nxt_s = t_rem_r - dt_eff_s;
        edge_s      = cke && (t_rem_nxt_s == DT_ZERO);
    end

    assign din_ready = (count_r != CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign push_s    = din_valid && din_ready;
    // Pop decision uses the registered count, so a same-cycle push cannot bypass to the edge.
    assign pop_s     = edge_s && !empty_s;

    // Select the symbol entering the history at an edge.
    always_comb begin
        sym_s = SYM_IDLE;
        if (empty_s) begin
            sym_s = SYM_IDLE;
        end else if (mem_r[rd_ptr_r]) begin
            sym_s = SYM_POS;
        end else begin
            sym_s = SYM_NEG;
        end
        hist_nxt_s = {hist_r, sym_s};
    end

    // Bit FIFO storage, pointers and occupancy; push is independent of cke.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r    <= {FIFO_DEPTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // UI timer and timestep error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_rem_r  <= UI_LEN_C;
            dt_err_r <= 1'b0;
        end else if (cke) begin
            t_rem_r <= edge_s ? UI_LEN_C : t_rem_nxt_s;
            if (dt_bad_s) begin
                dt_err_r <= 1'b1;
            end
        end
    end

    // Symbol history, FFE output sample and its one-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_r      <= {(HW-2){1'b0}};
            out_r       <= {OUT_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            out_valid_r <= edge_s;
            if (edge_s) begin
                hist_r <= hist_nxt_s[HW-3:0];
                out_r  <= ffe_sum(taps, hist_nxt_s);
                if (empty_s) begin
                    underflow_r <= 1'b1;
                end
            end
        end
    end

    assign dt_req    = t_rem_r;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign underflow = underflow_r;
    assign dt_err    = dt_err_r;

endmodule

// File: tb/tb_tx_emu_driver.sv
// Scoreboarded bench for tx_emu_driver: stimulus queues expected samples, a monitor checks each out_valid.
module tb_tx_emu_driver;

    localparam int DT_WIDTH = 27;
    localparam int OUT_W    = 16;

    logic                       clk;
    logic                       rst_n;
    logic                       cke;
    logic signed [DT_WIDTH-1:0] dt;
    logic signed [DT_WIDTH-1:0] dt_req;
    logic                       din;
    logic                       din_valid;
    logic                       din_ready;
    logic [23:0]                taps;
    logic signed [OUT_W-1:0]    out;
    logic                       out_valid;
    logic                       underflow;
    logic                       dt_err;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    tx_emu_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cke       (cke),
        .dt        (dt),
        .dt_req    (dt_req),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .taps      (taps),
        .out       (out),
        .out_valid (out_valid),
        .underflow (underflow),
        .dt_err    (dt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cke       = 1'b0;
        din_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_bit(input logic b);
        din       = b;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_unexpected: got out_valid=1 out=%0d, expected no pulse", out);
                end else begin
                    check("out_sample", out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int t1_req[8] = '{46875, 31250, 15625, 62500, 46875, 31250, 15625, 62500};
        int t6_req[4] = '{46875, 31250, 15625, 62500};
        int t5_out[9] = '{-100, 120, 75, 85, 85, 85, 85, 85, -15};
        logic [7:0] bits5;

        rst_n     = 1'b0;
        cke       = 1'b0;
        dt        = '0;
        din       = 1'b0;
        din_valid = 1'b0;
        taps      = {8'd5, 8'hec, 8'd100};
        step();
        step();
        check("rst_dt_req", dt_req, 62500);
        check("rst_din_ready", din_ready, 1);
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_underflow", underflow, 0);
        check("rst_dt_err", dt_err, 0);

        // Idle UIs of four quarter steps each.
        rst_n = 1'b1;
        cke   = 1'b1;
        dt    = 27'sd15625;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) exp_q.push_back(0);
            step();
            check("idle_dt_req", dt_req, t1_req[i]);
            if (i == 2) check("idle_underflow_pre", underflow, 0);
            if (i == 3) check("idle_underflow_post", underflow, 1);
        end
        cke = 1'b0;
        step();

        // FFE arithmetic: bits 1,1,0,1 with taps 100,-20,5.
        do_reset();
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b1);
        exp_q.push_back(100);
        exp_q.push_back(80);
        exp_q.push_back(-115);
        exp_q.push_back(125);
        cke = 1'b1;
        dt  = 27'sd62500;
        repeat (4) step();
        cke = 1'b0;
        check("ffe_underflow", underflow, 0);
        check("ffe_dt_err", dt_err, 0);
        step();

        // Zero and negative timesteps.
        do_reset();
        cke = 1'b1;
        dt  = 27'sd0;
        step();
        check("dt0_dt_req", dt_req, 62500);
        check("dt0_dt_err", dt_err, 0);
        dt = -27'sd5;
        step();
        check("dtneg_dt_err", dt_err, 1);
        check("dtneg_dt_req", dt_req, 62500);

        // Oversized timestep clipped onto the edge.
        do_reset();
        cke = 1'b1;
        dt  = 27'sd62400;
        step();
        check("clip_pre_dt_req", dt_req, 100);
        check("clip_pre_dt_err", dt_err, 0);
        dt = 27'sd150;
        exp_q.push_back(0);
        step();
        check("clip_dt_err", dt_err, 1);
        check("clip_dt_req", dt_req, 62500);
        cke = 1'b0;
        step();

        // cke freeze with half-UI steps.
        do_reset();
        dt  = 27'sd31250;
        cke = 1'b1;
        step();
        check("cke_dt_req_1", dt_req, 31250);
        cke = 1'b0;
        step();
        check("cke_dt_req_0a", dt_req, 31250);
        step();
        check("cke_dt_req_0b", dt_req, 31250);
        check("cke_underflow_pre", underflow, 0);
        cke = 1'b1;
        exp_q.push_back(0);
        step();
        check("cke_dt_req_edge", dt_req, 62500);
        check("cke_underflow_post", underflow, 1);
        check("cke_dt_err", dt_err, 0);
        cke = 1'b0;
        step();

        // FIFO full and backpressure; first pushed bit is 0.
        do_reset();
        bits5 = 8'b1111_1110;
        for (int i = 0; i < 8; i++) begin
            push_bit(bits5[i]);
            check("full_din_ready", din_ready, (i == 7) ? 0 : 1);
        end
        din       = 1'b1;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        check("full_ninth_din_ready", din_ready, 0);
        for (int i = 0; i < 9; i++) exp_q.push_back(t5_out[i]);
        cke = 1'b1;
        dt  = 27'sd62500;
        step();
        check("full_after_edge_din_ready", din_ready, 1);
        repeat (7) step();
        check("full_drain_underflow_pre", underflow, 0);
        step();
        check("full_drain_underflow_post", underflow, 1);
        cke = 1'b0;
        step();

        // Asynchronous reset in the middle of a UI with bits queued and out nonzero.
        push_bit(1'b1);
        push_bit(1'b1);
        push_bit(1'b1);
        cke = 1'b1;
        dt  = 27'sd32500;
        step();
        check("mid_dt_req_pre", dt_req, 30000);
        cke = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", out, 0);
        check("mid_rst_dt_req", dt_req, 62500);
        check("mid_rst_din_ready", din_ready, 1);
        check("mid_rst_underflow", underflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cke   = 1'b1;
        dt    = 27'sd15625;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(0);
            step();
            check("mid_dt_req", dt_req, t6_req[i]);
        end
        check("mid_underflow", underflow, 1);
        cke = 1'b0;
        step();
        step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_emu_driver.md
Name: tx_emu_driver

Overview:
- Emulated serial transmitter: the source end of the FPGA channel emulation.
- Takes a bit stream from a small FIFO, maps each bit to a ±1 symbol and applies a NUM_TAPS feed-forward equalizer.
- Drives the channel model's signed fixed-point analog input once per unit interval (UI).
- Tracks UI time against the emulator timestep and requests the timestep that lands exactly on the next UI edge.

Parameters:
- DT_WIDTH, 27: width of the signed timestep words `dt` and `dt_req`.
- UI_LEN, 62500: UI length in dt LSBs; must satisfy 0 < UI_LEN < 2^(DT_WIDTH-1).
- NUM_TAPS, 3: FFE taps; tap 0 is the main cursor, tap k is the k-th post-cursor.
- TAP_WIDTH, 8: signed width of each tap.
- OUT_WIDTH, 16: signed width of `out`; must be ≥ TAP_WIDTH + clog2(NUM_TAPS) + 1.
- FIFO_DEPTH, 8: bit FIFO depth; must be a power of two, ≥ 2.

Ports:
- clk, in, 1: emulator clock.
- rst_n, in, 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- cke, in, 1: emulator step enable. State advances only on cycles where cke=1.
- dt, in, DT_WIDTH (signed): timestep actually taken this step.
- dt_req, out, DT_WIDTH (signed): requested timestep (time remaining to the next UI edge).
- din, in, 1: data bit.
- din_valid, in, 1: din is valid.
- din_ready, out, 1: FIFO can accept din.
- taps, in, NUM_TAPS*TAP_WIDTH: signed taps packed with tap 0 in the LSBs. Quasi-static; sampled at UI edges only.
- out, out, OUT_WIDTH (signed): analog value presented to the channel input.
- out_valid, out, 1: one-cycle pulse marking a new `out` value.
- underflow, out, 1: sticky flag; FIFO was empty at a UI edge.
- dt_err, out, 1: sticky flag; dt exceeded the remaining UI time, or dt was negative.

Behaviour:

Reset (rst_n=0, async):
- t_rem=UI_LEN, dt_req=UI_LEN, FIFO empty, din_ready=1.
- Symbol history all idle (0).
- out=0, out_valid=0, underflow=0, dt_err=0.
- Reset mid-UI discards FIFO contents and history; the first UI after release is a full UI_LEN.

FIFO:
- Push when din_valid && din_ready.
- din_ready = !full, combinational from the registered count.
- Pop only at a UI edge.
- Push into an empty FIFO in the same cycle as an edge does not bypass: the edge sees empty.
- Push and pop in the same cycle keep the count unchanged.

UI timer (only when cke=1):
- If dt<0: set dt_err and treat dt as 0.
- If dt>t_rem: set dt_err and treat dt as t_rem.
- Then t_rem_next = t_rem - dt.
- If t_rem_next==0, the cycle is a UI edge and t_rem reloads to UI_LEN.
- dt=0 is legal and does not advance time.
- cke=0 freezes every state element except FIFO push and din_ready.
- dt_req is a register equal to t_rem, updated the same cycle; it is always in 1..UI_LEN.

UI edge:
- Pop the FIFO head. Bit 1 maps to symbol +1, bit 0 to symbol -1.
- If the FIFO is empty, use the idle symbol 0 and set underflow.
- Shift the symbol into history h[0] (newest); h[k] ← h[k-1], and h[NUM_TAPS-1] is dropped.

Output:
- On the cycle after an edge: out = Σ taps[k]·h[k] over the updated history, sign-extended, exact with no saturation (guaranteed by the OUT_WIDTH rule).
- out_valid=1 for exactly that one cycle. out holds its value between edges.
- Latency from the edge cycle to out_valid is 1 clk, independent of cke on the following cycle.

Sticky flags:
- underflow and dt_err clear only on reset.

Test Plan:
- Reset and idle: hold rst_n=0, then release with cke=1, dt=UI_LEN/4=15625, no data. Required: dt_req sequence 62500→46875→31250→15625, then edge; out=0 with one out_valid pulse per 4 cycles; underflow=1 after the first edge.
- FFE arithmetic: taps={t0=100, t1=-20, t2=5}; push bits 1,1,0,1 before the first edge; dt=UI_LEN each step. Required out sequence: 100, 80, -115, 125.
- Timestep clipping: t_rem=100, apply dt=150. Required: dt_err=1, edge occurs, t_rem reloads to 62500. Separately, dt=-5 sets dt_err and leaves t_rem unchanged.
- cke freeze: dt=UI_LEN/2 with cke toggling 1,0,0,1. Required: edge only on the second cke=1 cycle; dt_req unchanged across the cke=0 cycles; no out_valid while cke=0.
- FIFO full/backpressure: push 8 bits with no edges. Required: din_ready=0 after the 8th push; a 9th din_valid is not accepted; after one edge, din_ready=1 and exactly the first-pushed bit was consumed.
- Reset mid-UI: t_rem=30000, FIFO holding 3 bits, assert rst_n=0 asynchronously between clock edges. Required: immediately out=0, dt_req=62500, din_ready=1; after release, first out_valid only after a full UI and underflow=1.
